// File: rtl/safe_pkg.sv
// safe_pkg: shared FSM states and constants for the safe entry front-end
package safe_pkg;
   typedef enum logic [1:0] {COLLECT, SUBMIT, WAIT_RESULT, LOCKOUT} state_t;
   localparam logic [3:0] CANCEL_KEY = 4'hF;
   localparam int CODE_W = 16;
   localparam int DIGITS = 4;
endpackage

// File: rtl/safe_entry_ctrl_confirm_debouncer.sv
// confirm_debouncer: 2-flop synchronizer, stability counter and rising-edge press strobe
module confirm_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic confirm,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0] sync;
   logic db, db_q;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sync <= '0;
         db   <= 1'b0;
         db_q <= 1'b0;
         cnt  <= '0;
      end else begin
         sync <= {sync[0], confirm};
         db_q <= db;
         if (sync[1] == db) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            db  <= sync[1];
            cnt <= '0;
         end else cnt <= cnt + CW'(1);
      end
   assign press = db & ~db_q;
endmodule

// File: rtl/safe_entry_ctrl.sv
// safe_entry_ctrl: passcode entry sequencer for the safe core; SAFE_ENTRY_TIMEOUT_EN enables the partial-entry timeout
module safe_entry_ctrl
   import safe_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TIMEOUT_CYCLES  = 100000000,
   parameter int MAX_FAIL        = 3,
   parameter int LOCKOUT_CYCLES  = 250000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              confirm,
   input  logic [3:0]        keypad,
   output logic [CODE_W-1:0] code,
   output logic              code_valid,
   input  logic              code_ready,
   input  logic              result_valid,
   input  logic              result_ok,
   output logic [CODE_W-1:0] entry_digits,
   output logic [2:0]        digit_cnt,
   output logic              locked,
   output logic [1:0]        fail_cnt,
   output logic              timeout
);
   localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
   state_t state, state_n;
   logic press, expire, verdict;
   logic [3:0] key_s1, key_s2;
   logic [LW-1:0] lock_cnt;
   confirm_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk), .reset(reset), .confirm(confirm), .press(press)
   );
   assign verdict = state == WAIT_RESULT && result_valid;
   always_comb begin
      state_n = state;
      case (state)
         COLLECT:     if (press && key_s2 != CANCEL_KEY && digit_cnt == 3'(DIGITS - 1)) state_n = SUBMIT;
         SUBMIT:      if (code_ready) state_n = WAIT_RESULT;
         WAIT_RESULT: if (result_valid) state_n = (!result_ok && fail_cnt == 2'(MAX_FAIL - 1)) ? LOCKOUT : COLLECT;
         LOCKOUT:     if (lock_cnt <= LW'(1)) state_n = COLLECT;
         default:     state_n = COLLECT;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= COLLECT;
      else state <= state_n;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         key_s1       <= '0;
         key_s2       <= '0;
         entry_digits <= '0;
         digit_cnt    <= '0;
         fail_cnt     <= '0;
         lock_cnt     <= '0;
      end else begin
         key_s1 <= keypad;
         key_s2 <= key_s1;
         if (state == COLLECT && press) begin
            if (key_s2 == CANCEL_KEY) begin
               entry_digits <= '0;
               digit_cnt    <= '0;
            end else begin
               entry_digits[{~digit_cnt[1:0], 2'b00} +: 4] <= key_s2;
               digit_cnt <= digit_cnt + 3'd1;
            end
         end else if (expire || verdict) begin
            entry_digits <= '0;
            digit_cnt    <= '0;
         end
         if (verdict) fail_cnt <= result_ok ? 2'd0 : (fail_cnt == 2'd3 ? fail_cnt : fail_cnt + 2'd1);
         else if (state == LOCKOUT && state_n == COLLECT) fail_cnt <= '0;
         if (state != LOCKOUT && state_n == LOCKOUT) lock_cnt <= LW'(LOCKOUT_CYCLES);
         else if (lock_cnt != '0) lock_cnt <= lock_cnt - LW'(1);
      end
`ifdef SAFE_ENTRY_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;
   logic partial;
   assign partial = state == COLLECT && digit_cnt != 3'd0 && digit_cnt != 3'(DIGITS);
   assign expire  = partial && !press && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout  <= expire;
         idle_cnt <= (!partial || press || expire) ? '0 : idle_cnt + TW'(1);
      end
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif
   assign code_valid = state == SUBMIT;
   assign code       = code_valid ? entry_digits : '0;
   assign locked     = state == LOCKOUT;
endmodule

// File: tb/tb_safe_entry_ctrl.sv
// tb_safe_entry_ctrl: scoreboard-driven bench for safe_entry_ctrl with short debounce/timeout/lockout settings
module tb_safe_entry_ctrl;
   logic clk = 1'b0, reset = 1'b1, confirm = 1'b0, code_ready = 1'b0, result_valid = 1'b0, result_ok = 1'b0;
   logic [3:0] keypad = 4'h0;
   logic [15:0] code, entry_digits;
   logic code_valid, locked, timeout;
   logic [2:0] digit_cnt;
   logic [1:0] fail_cnt;
   int checks = 0, errors = 0;
   int fail_exp = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   safe_entry_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50), .MAX_FAIL(3), .LOCKOUT_CYCLES(20)) dut (
      .clk(clk), .reset(reset), .confirm(confirm), .keypad(keypad), .code(code), .code_valid(code_valid),
      .code_ready(code_ready), .result_valid(result_valid), .result_ok(result_ok), .entry_digits(entry_digits),
      .digit_cnt(digit_cnt), .locked(locked), .fail_cnt(fail_cnt), .timeout(timeout)
   );

   task automatic press_key(input logic [3:0] k);
      keypad = k;
      confirm = 1'b1;
      repeat (8) @(negedge clk);
      confirm = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic submit(input logic [15:0] c);
      exp_q.push_back(c);
      for (int i = 3; i >= 0; i--) press_key(c[4*i +: 4]);
   endtask

   task automatic handshake(input int hold);
      logic [15:0] e;
      int n = 0;
      while (!code_valid && n < 40) begin n++; @(negedge clk); end
      e = exp_q.pop_front();
      checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL hs_valid: got %b want 1", code_valid); end
      repeat (hold) begin
         checks++; if (code !== e) begin errors++; $display("FAIL hs_hold_code: got %h want %h", code, e); end
         @(negedge clk);
      end
      checks++; if (code !== e) begin errors++; $display("FAIL hs_code: got %h want %h", code, e); end
      code_ready = 1'b1;
      @(negedge clk);
      code_ready = 1'b0;
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL hs_drop: got %b want 0", code_valid); end
   endtask

   task automatic verdict(input logic ok);
      result_ok = ok;
      result_valid = 1'b1;
      @(negedge clk);
      result_valid = 1'b0;
      result_ok = 1'b0;
      fail_exp = ok ? 0 : fail_exp + 1;
      checks++; if (locked !== (fail_exp == 3)) begin errors++; $display("FAIL verdict_locked: got %b want %b", locked, fail_exp == 3); end
      if (fail_exp < 3) begin
         checks++; if (fail_cnt !== 2'(fail_exp)) begin errors++; $display("FAIL verdict_fail_cnt: got %0d want %0d", fail_cnt, fail_exp); end
      end
      checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL verdict_clear: got %0d want 0", digit_cnt); end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++; if (code_valid !== 1'b0 || code !== 16'h0) begin errors++; $display("FAIL reset_code: got %b/%h want 0/0000", code_valid, code); end
      checks++; if (digit_cnt !== 3'd0 || entry_digits !== 16'h0) begin errors++; $display("FAIL reset_entry: got %0d/%h want 0/0000", digit_cnt, entry_digits); end
      checks++; if (locked !== 1'b0 || fail_cnt !== 2'd0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_status: got %b/%0d/%b want 0/0/0", locked, fail_cnt, timeout); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_entry;
      logic [15:0] c = 16'h1234;
      logic [15:0] e = 16'h0;
      exp_q.push_back(c);
      for (int i = 0; i < 4; i++) begin
         press_key(c[4*(3-i) +: 4]);
         e[4*(3-i) +: 4] = c[4*(3-i) +: 4];
         if (i < 3) begin
            checks++; if (digit_cnt !== 3'(i + 1) || entry_digits !== e) begin errors++; $display("FAIL entry_%0d: got %0d/%h want %0d/%h", i, digit_cnt, entry_digits, i + 1, e); end
         end
      end
      handshake(5);
      verdict(1'b1);
   endtask

   task automatic test_glitch;
      confirm = 1'b1; keypad = 4'h6;
      repeat (3) @(negedge clk);
      confirm = 1'b0;
      repeat (12) @(negedge clk);
      checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL glitch_short: got %0d want 0", digit_cnt); end
      confirm = 1'b1;
      repeat (5) @(negedge clk);
      confirm = 1'b0;
      repeat (12) @(negedge clk);
      checks++; if (digit_cnt !== 3'd1 || entry_digits !== 16'h6000) begin errors++; $display("FAIL glitch_long: got %0d/%h want 1/6000", digit_cnt, entry_digits); end
      press_key(4'hF);
   endtask

   task automatic test_cancel;
      press_key(4'h7);
      press_key(4'h8);
      checks++; if (digit_cnt !== 3'd2 || entry_digits !== 16'h7800) begin errors++; $display("FAIL cancel_pre: got %0d/%h want 2/7800", digit_cnt, entry_digits); end
      press_key(4'hF);
      checks++; if (digit_cnt !== 3'd0 || entry_digits !== 16'h0) begin errors++; $display("FAIL cancel_clear: got %0d/%h want 0/0000", digit_cnt, entry_digits); end
      press_key(4'h1); press_key(4'h2); press_key(4'h3);
      checks++; if (digit_cnt !== 3'd3 || code_valid !== 1'b0) begin errors++; $display("FAIL cancel_three: got %0d/%b want 3/0", digit_cnt, code_valid); end
      press_key(4'hF);
   endtask

   task automatic test_lockout;
      int n = 0;
      for (int i = 0; i < 3; i++) begin
         submit(16'h9990 + 16'(i));
         handshake(0);
         verdict(1'b0);
      end
      while (locked && n < 100) begin
         n++;
         if (n == 1) begin keypad = 4'h5; confirm = 1'b1; end
         if (n == 12) confirm = 1'b0;
         @(negedge clk);
      end
      confirm = 1'b0;
      fail_exp = 0;
      checks++; if (n !== 20) begin errors++; $display("FAIL lockout_len: got %0d want 20", n); end
      checks++; if (locked !== 1'b0 || fail_cnt !== 2'd0 || digit_cnt !== 3'd0) begin errors++; $display("FAIL lockout_exit: got %b/%0d/%0d want 0/0/0", locked, fail_cnt, digit_cnt); end
      repeat (10) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         submit(16'h4321);
         handshake(0);
         verdict(1'b0);
      end
      submit(16'h2468);
      handshake(1);
      verdict(1'b1);
   endtask

   task automatic test_timeout;
      int pulses = 0;
      press_key(4'h9);
      checks++; if (digit_cnt !== 3'd1) begin errors++; $display("FAIL timeout_digit: got %0d want 1", digit_cnt); end
      repeat (60) begin @(negedge clk); if (timeout) pulses++; end
`ifdef SAFE_ENTRY_TIMEOUT_EN
      checks++; if (pulses !== 1) begin errors++; $display("FAIL timeout_pulse: got %0d want 1", pulses); end
      checks++; if (digit_cnt !== 3'd0 || entry_digits !== 16'h0) begin errors++; $display("FAIL timeout_clear: got %0d/%h want 0/0000", digit_cnt, entry_digits); end
`else
      checks++; if (pulses !== 0) begin errors++; $display("FAIL timeout_pulse: got %0d want 0", pulses); end
      checks++; if (digit_cnt !== 3'd1) begin errors++; $display("FAIL timeout_keep: got %0d want 1", digit_cnt); end
      press_key(4'hF);
`endif
   endtask

   task automatic test_reset_mid;
      int n = 0;
      submit(16'h5678);
      while (!code_valid && n < 40) begin n++; @(negedge clk); end
      checks++; if (code_valid !== 1'b1 || code !== 16'h5678) begin errors++; $display("FAIL mid_valid: got %b/%h want 1/5678", code_valid, code); end
      #2 reset = 1'b1;
      #1;
      checks++; if (code_valid !== 1'b0 || code !== 16'h0) begin errors++; $display("FAIL mid_code: got %b/%h want 0/0000", code_valid, code); end
      checks++; if (digit_cnt !== 3'd0 || entry_digits !== 16'h0) begin errors++; $display("FAIL mid_entry: got %0d/%h want 0/0000", digit_cnt, entry_digits); end
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_entry();
      test_glitch();
      test_cancel();
      test_lockout();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/safe_entry_ctrl.md
# safe_entry_ctrl

Clocked front-end controller that sequences passcode entry for the safe core. It synchronizes and debounces the `confirm` button, collects four keypad digits into a 16-bit code, and hands the code to the safe core through a valid/ready handshake. It then waits for the core's verdict and counts consecutive failures, enforcing a timed lockout. It sits between the board buttons/switches and the safe core, replacing the core's direct use of `confirm` as a clock.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: cycles a new `confirm` level must stay stable before it is accepted.
- `TIMEOUT_CYCLES`, default 100000000: idle cycles allowed between digits before a partial entry is discarded.
- `MAX_FAIL`, default 3: consecutive failed codes that trigger lockout.
- `LOCKOUT_CYCLES`, default 250000000: lockout duration in cycles.

Ports:
- `clk` input 1: single system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `confirm` input 1: raw, bouncy push-button.
- `keypad` input 4: raw digit switches.
- `code` output 16: assembled code; first digit in [15:12], last digit in [3:0].
- `code_valid` output 1: a code is offered to the core.
- `code_ready` input 1: the core accepts the code.
- `result_valid` input 1: single-cycle verdict strobe from the core.
- `result_ok` input 1: verdict; 1 means the code matched.
- `entry_digits` output 16: digits entered so far, for display; positions not yet entered read 0.
- `digit_cnt` output 3: number of digits entered, 0..4.
- `locked` output 1: high during lockout.
- `fail_cnt` output 2: current consecutive-failure count.
- `timeout` output 1: single-cycle pulse when a partial entry is discarded.

## Operation
- Input conditioning:
  - `confirm` and `keypad` each pass through a 2-flop synchronizer.
  - The debouncer accepts a new `confirm` level after `DEBOUNCE_CYCLES` consecutive cycles at that level; any change in between restarts the count.
  - Each accepted 0→1 transition produces a one-cycle `press` strobe. Release produces no strobe.
- State machine: `COLLECT` → `SUBMIT` → `WAIT_RESULT` → `COLLECT` or `LOCKOUT`.
- `COLLECT`:
  - On `press` with synchronized keypad = 4'hF (cancel key): clear `entry_digits` and set `digit_cnt` to 0.
  - On `press` with any other value: write the digit into nibble `3-digit_cnt` and increment `digit_cnt`.
  - The press that brings `digit_cnt` to 4 moves the FSM to `SUBMIT`.
- `SUBMIT`:
  - `code_valid` is high and `code` equals `entry_digits`; both hold stable until `code_valid && code_ready`.
  - After the transfer, go to `WAIT_RESULT`.
- `WAIT_RESULT`, on `result_valid`:
  - If `result_ok`: clear `fail_cnt`, go to `COLLECT`.
  - Otherwise increment `fail_cnt`. If it reaches `MAX_FAIL`, go to `LOCKOUT`; if not, go to `COLLECT`.
  - In both cases the entry clears on exit.
- `LOCKOUT`:
  - `locked` is high and the lockout counter is loaded with `LOCKOUT_CYCLES`, then decrements each cycle.
  - At 0, go to `COLLECT` and clear `fail_cnt`.
- Presses outside `COLLECT` are dropped. `result_valid` outside `WAIT_RESULT` is ignored. `code_ready` outside `SUBMIT` is ignored.
- Counter widths are `$clog2(param+1)`. Counters saturate and never wrap.
- Reset values:
  - FSM in `COLLECT`.
  - `code`, `entry_digits` = 16'h0000; `digit_cnt`, `fail_cnt` = 0.
  - `code_valid`, `locked`, `timeout` = 0.
  - Debounced level = 0; all counters = 0.
- Reset asserted mid-entry, mid-handshake, or during lockout returns everything to the reset values immediately.

## Timing
- Raw `confirm` rise (bounce-free) → `press` strobe after 2 + `DEBOUNCE_CYCLES` + 1 cycles.
- `press` in cycle N → `digit_cnt` and `entry_digits` updated at N+1.
- 4th `press` in cycle N → `code_valid` = 1 at N+1.
- Handshake transfer in cycle M → `code_valid` = 0 at M+1.
- `result_valid` in cycle R → new state, `fail_cnt` and `locked` visible at R+1.
- `locked` stays high for exactly `LOCKOUT_CYCLES` cycles.
- If a `press` and a timeout expiry fall in the same cycle, the press wins and the idle counter restarts.

## Configuration
- Macro: `SAFE_ENTRY_TIMEOUT_EN`.
- Defined:
  - In `COLLECT` with `digit_cnt` of 1..3, an idle counter increments every cycle and resets on `press`.
  - When it reaches `TIMEOUT_CYCLES`, the entry clears, `digit_cnt` goes to 0, and `timeout` pulses for 1 cycle.
- Undefined: no idle counter; `timeout` is tied 0; partial entries are kept indefinitely.

## Structure
- Shared package `safe_pkg`:
  - FSM state enum (`COLLECT`, `SUBMIT`, `WAIT_RESULT`, `LOCKOUT`).
  - `CANCEL_KEY` = 4'hF.
  - `CODE_W` = 16, `DIGITS` = 4.
- One sub-module, `confirm_debouncer`: synchronizer, stability counter and rising-edge strobe. Parameterized by `DEBOUNCE_CYCLES`.

## Test plan
Bench settings: `DEBOUNCE_CYCLES`=4, `TIMEOUT_CYCLES`=50, `MAX_FAIL`=3, `LOCKOUT_CYCLES`=20.
- Four clean presses with keypad 1,2,3,4 → `code_valid` with `code`=16'h1234. With `code_ready` held low for 5 cycles, `code` stays stable; `code_ready` pulse → `code_valid` drops next cycle.
- `confirm` glitching high for 3 cycles → no press and `digit_cnt` stays 0. Glitching high 5 cycles → exactly one press.
- Digits 7,8, then keypad F press → `digit_cnt`=0 and `entry_digits`=16'h0000. Three more digits → still `COLLECT`, no `code_valid`.
- Three submissions each answered with `result_ok`=0 → `fail_cnt` steps 1,2, then `locked`=1 for exactly 20 cycles with presses ignored; then `locked`=0 and `fail_cnt`=0. A success after 2 fails clears `fail_cnt` to 0.
- With `SAFE_ENTRY_TIMEOUT_EN`: one digit then 50 idle cycles → `timeout` pulses once and `digit_cnt`=0. Without the macro, `digit_cnt` stays 1.
- Reset asserted while `code_valid`=1 → same-cycle return to reset values; `code_valid`=0 and `code`=0.
